// File: rtl/memory_responder_pkg.sv
// Shared types and defaults for the memory_responder block.
package memory_responder_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 256;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Request fields captured when a transaction is accepted.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

endpackage

// File: rtl/memory_responder_array.sv
// Word storage: synchronous write, registered read, contents never reset.
module memory_responder_array
  import memory_responder_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Write port and read register share one enable-qualified edge.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_responder.sv
// Single-initiator memory responder with a fixed number of wait states.
// Address error checking is compiled in with MEMORY_RESPONDER_ERR_EN; without
// it addr_err stays 0, addr[1:0] is ignored and the word index wraps.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              addr_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  txn_t              txn_q, txn_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic              rvld_q, rvld_d;

  logic              fire_c;
  logic              err_c;
  logic              we_c;
  logic              re_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] arr_rdata;

  // The terminal WAIT cycle (counter at zero) is the edge that enters RESP.
  assign fire_c = (state_q == WAIT) && (cnt_q == '0);
  assign idx_c  = txn_q.addr[IDX_W+1:2];

`ifdef MEMORY_RESPONDER_ERR_EN
  // Misaligned or beyond-depth addresses are rejected.
  assign err_c = (txn_q.addr[1:0] != 2'b00) || ((txn_q.addr >> (IDX_W + 2)) != '0);
`else
  logic unused_addr_c;
  assign err_c         = 1'b0;
  assign unused_addr_c = ^{txn_q.addr[ADDR_W-1:IDX_W+2], txn_q.addr[1:0]};
`endif

  assign we_c = fire_c &  txn_q.wr & ~err_c;
  assign re_c = fire_c & ~txn_q.wr & ~err_c;

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txn_d   = txn_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rvld_d  = rvld_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          txn_d.wr    = wr;
          txn_d.addr  = addr;
          txn_d.wdata = wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = err_c;
          if (re_c) rvld_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; storage is deliberately outside this reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      txn_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rvld_q  <= rvld_d;
    end
  end

  memory_responder_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .we_i    (we_c),
    .re_i    (re_c),
    .idx_i   (idx_c),
    .wdata_i (txn_q.wdata),
    .rdata_o (arr_rdata)
  );

  // rvld_q masks the unreset read register until a read lands after reset.
  assign rdata    = rvld_q ? arr_rdata : '0;
  assign ready    = ready_q;
  assign addr_err = err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (2 and 0 wait states) checked
// every cycle against a transaction-level model, plus literal scenario checks.
module tb_memory_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned W0    = 2;
  localparam int unsigned W1    = 0;
`ifdef MEMORY_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req      [2];
  logic        wr       [2];
  logic [31:0] addr     [2];
  logic [31:0] wdata    [2];
  logic [31:0] rdata    [2];
  logic        ready    [2];
  logic        addr_err [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned edge_no = 0;

  always #5 clk = ~clk;

  memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .reset(rst_n), .req(req[0]), .wr(wr[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .addr_err(addr_err[0])
  );

  memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .reset(rst_n), .req(req[1]), .wr(wr[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .addr_err(addr_err[1])
  );

  // ---------------- transaction-level model ----------------
  int unsigned waits [2] = '{W0, W1};
  bit          inflight [2];
  int unsigned done_e   [2];
  int unsigned next_ok  [2];
  bit          t_wr     [2];
  logic [31:0] t_addr   [2];
  logic [31:0] t_wdata  [2];
  logic [31:0] m_mem    [int];
  logic [31:0] m_rdata  [2];
  bit          m_rknown [2];
  bit          exp_ready[2];
  bit          exp_err  [2];
  logic        s_req    [2];
  logic        s_wr     [2];
  logic [31:0] s_addr   [2];
  logic [31:0] s_wdata  [2];
  logic        s_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // A request accepted at edge S makes ready rise at edge S+W+1 (high during
  // the (W+2)th cycle) and the next request may be accepted at edge S+W+3.
  task automatic model_step(input int k);
    bit err;
    int key;
    exp_ready[k] = 1'b0;
    exp_err[k]   = 1'b0;
    if (!s_rst) begin
      inflight[k] = 1'b0;
      next_ok[k]  = 0;
      m_rdata[k]  = '0;
      m_rknown[k] = 1'b1;
    end else if (inflight[k] && edge_no == done_e[k]) begin
      err = ERR_EN && (((t_addr[k] % 4) != 0) || (t_addr[k] >= 4 * DEPTH));
      key = k * 4096 + int'((t_addr[k] / 4) % DEPTH);
      if (!err) begin
        if (t_wr[k]) m_mem[key] = t_wdata[k];
        else if (m_mem.exists(key)) begin
          m_rdata[k]  = m_mem[key];
          m_rknown[k] = 1'b1;
        end else m_rknown[k] = 1'b0;
      end
      exp_ready[k] = 1'b1;
      exp_err[k]   = err;
      inflight[k]  = 1'b0;
    end else if (!inflight[k] && edge_no >= next_ok[k] && s_req[k]) begin
      t_wr[k]     = s_wr[k];
      t_addr[k]   = s_addr[k];
      t_wdata[k]  = s_wdata[k];
      done_e[k]   = edge_no + waits[k] + 1;
      next_ok[k]  = edge_no + waits[k] + 3;
      inflight[k] = 1'b1;
    end
  endtask

  // Per-cycle compare of both instances against the model.
  always begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      s_req[k]   = req[k];
      s_wr[k]    = wr[k];
      s_addr[k]  = addr[k];
      s_wdata[k] = wdata[k];
    end
    s_rst = rst_n;
    #1;
    edge_no++;
    for (int k = 0; k < 2; k++) begin
      model_step(k);
      chk($sformatf("ready[%0d]@%0d", k, edge_no), 32'(ready[k]), 32'(exp_ready[k]));
      chk($sformatf("addr_err[%0d]@%0d", k, edge_no), 32'(addr_err[k]), 32'(exp_err[k]));
      if (m_rknown[k])
        chk($sformatf("rdata[%0d]@%0d", k, edge_no), rdata[k], m_rdata[k]);
    end
  end

  // ---------------- stimulus ----------------
  // lat = index of the cycle after the sampling edge in which ready is high.
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic er);
    int unsigned s;
    bit seen;
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
    @(posedge clk);
    #2;
    s = edge_no;
    @(negedge clk);
    wr[k] = ~w; addr[k] = ~a; wdata[k] = ~d;
    lat = -1; rd = '0; er = 1'b0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (ready[k]) begin
        seen = 1'b1;
        lat  = int'(edge_no - s) + 1;
        rd   = rdata[k];
        er   = addr_err[k];
        req[k] = 1'b0;
      end else @(negedge clk);
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      req[k] = 1'b0;
      $display("FAIL txn%0d timeout: got no ready in 40 cycles, expected ready", k);
    end
  endtask

  task automatic burst3(input int k, input logic [31:0] a, input int unsigned gap);
    int unsigned rise [3];
    int n;
    @(negedge clk);
    req[k] = 1'b1; wr[k] = 1'b0; addr[k] = a;
    n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      if (ready[k]) begin
        rise[n] = edge_no;
        n++;
      end
    end
    req[k] = 1'b0;
    if (n < 3) begin
      n_cmp++; n_bad++;
      $display("FAIL burst%0d: got %0d ready pulses, expected 3", k, n);
    end else begin
      chk($sformatf("burst%0d gap1", k), 32'(rise[1] - rise[0]), 32'(gap));
      chk($sformatf("burst%0d gap2", k), 32'(rise[2] - rise[1]), 32'(gap));
    end
    @(negedge clk);
    chk($sformatf("burst%0d ready width", k), 32'(ready[k]), 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset ready[%0d]", k), 32'(ready[k]), 32'd0);
      chk($sformatf("reset addr_err[%0d]", k), 32'(addr_err[k]), 32'd0);
      chk($sformatf("reset rdata[%0d]", k), rdata[k], 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Write then read back, default wait states.
    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    chk("wr 0x10 latency", 32'(lat), 32'd4);
    chk("wr 0x10 addr_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("rd 0x10 latency", 32'(lat), 32'd4);
    chk("rd 0x10 rdata", rd, 32'hDEADBEEF);
    chk("rd 0x10 addr_err", 32'(er), 32'd0);

    // Zero wait states.
    txn(1, 1'b1, 32'h0, 32'h12345678, lat, rd, er);
    chk("w0 wr latency", 32'(lat), 32'd2);
    txn(1, 1'b0, 32'h0, 32'h0, lat, rd, er);
    chk("w0 rd latency", 32'(lat), 32'd2);
    chk("w0 rd rdata", rd, 32'h12345678);

`ifdef MEMORY_RESPONDER_ERR_EN
    txn(0, 1'b1, 32'h13, 32'hFFFFFFFF, lat, rd, er);
    chk("misaligned wr addr_err", 32'(er), 32'd1);
    chk("misaligned wr latency", 32'(lat), 32'd4);
    chk("misaligned wr rdata held", rd, 32'hDEADBEEF);
    txn(0, 1'b1, 32'h400, 32'hA5A5A5A5, lat, rd, er);
    chk("out of range wr addr_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("rd 0x10 after errors", rd, 32'hDEADBEEF);
    chk("rd 0x10 after errors addr_err", 32'(er), 32'd0);
`else
    txn(0, 1'b1, 32'h400, 32'hA5A5A5A5, lat, rd, er);
    chk("wrap wr addr_err", 32'(er), 32'd0);
    chk("wrap wr rdata held", rd, 32'hDEADBEEF);
    txn(0, 1'b0, 32'h0, 32'h0, lat, rd, er);
    chk("wrap rd 0x0", rd, 32'hA5A5A5A5);
    txn(0, 1'b0, 32'h13, 32'h0, lat, rd, er);
    chk("rd 0x13 ignores low bits", rd, 32'hDEADBEEF);
    chk("rd 0x13 addr_err", 32'(er), 32'd0);
`endif

    // req held high across three transactions.
    burst3(0, 32'h10, 5);
    burst3(1, 32'h0, 3);

    // Reset in the middle of WAIT abandons the write.
    txn(0, 1'b1, 32'h20, 32'h0BADF00D, lat, rd, er);
    txn(0, 1'b0, 32'h10, 32'h0, lat, rd, er);
    chk("pre-reset rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req[0] = 1'b0;
    #1;
    chk("mid-wait reset ready", 32'(ready[0]), 32'd0);
    chk("mid-wait reset rdata", rdata[0], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h20, 32'h0, lat, rd, er);
    chk("post-reset rd latency", 32'(lat), 32'd4);
    chk("post-reset rd 0x20", rd, 32'h0BADF00D);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "time limit");
  end

endmodule
